// File: rtl/router_pkt_tx.sv
`default_nettype none
// =============================================================================
// router_pkt_tx : serial packet transmitter (address, pad, payload, gap).
// Define ROUTER_TX_PARITY_EN to append an even-parity bit after the payload.
// Revision: 1.0
// =============================================================================
module router_pkt_tx #(
   parameter int ADDR_W     = 2,
   parameter int PAD_CYCLES = 3,
   parameter int MAX_BYTES  = 16
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [ADDR_W-1:0]           req_addr,
   input  logic [$clog2(MAX_BYTES):0]  req_len,
   input  logic                        byte_valid,
   output logic                        byte_ready,
   input  logic [7:0]                  byte_data,
   output logic                        dout,
   output logic                        frame_n,
   output logic                        valid_n,
   output logic                        busy,
   output logic                        done
);

   localparam int LEN_W = $clog2(MAX_BYTES) + 1;
   localparam int CNT_W = ($clog2(ADDR_W + 1) > 4) ? $clog2(ADDR_W + 1) : 4;
   localparam logic [LEN_W-1:0] c_MAX_LEN   = LEN_W'(MAX_BYTES);
   localparam logic [CNT_W-1:0] c_ADDR_LAST = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] c_PAD_LAST  = CNT_W'(PAD_CYCLES - 1);
`ifdef ROUTER_TX_PARITY_EN
   localparam logic c_PARITY_EN = 1'b1;
`else
   localparam logic c_PARITY_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ADDR   = 3'd1,
      S_PAD    = 3'd2,
      S_DATA   = 3'd3,
      S_PARITY = 3'd4,
      S_GAP    = 3'd5
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [LEN_W-1:0]  r_bytes_left;   // bytes not yet pulled from the stream
   logic [CNT_W-1:0]  r_cnt;
   logic [7:0]        r_shift;
   logic [2:0]        r_bit;
   logic              r_loaded;
   logic              r_parity;
   logic [LEN_W-1:0]  w_len;
   logic              w_take;

   always_comb begin
      w_len = (req_len > c_MAX_LEN) ? c_MAX_LEN : req_len;
   end

   assign req_ready  = reset_n && (r_state == S_IDLE);
   // Ready one cycle ahead of a byte boundary so streamed bytes leave no bubble.
   assign byte_ready = reset_n &&
                       ((r_state == S_PAD  && r_cnt == c_PAD_LAST) ||
                        (r_state == S_DATA && (!r_loaded ||
                                               (r_bit == 3'd7 && r_bytes_left != '0))));
   assign w_take     = byte_valid && byte_ready;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         dout         <= 1'b0;
         frame_n      <= 1'b1;
         valid_n      <= 1'b1;
         busy         <= 1'b0;
         done         <= 1'b0;
         r_addr       <= '0;
         r_bytes_left <= '0;
         r_cnt        <= '0;
         r_shift      <= '0;
         r_bit        <= '0;
         r_loaded     <= 1'b0;
         r_parity     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (w_take) begin
            r_state      <= S_DATA;
            dout         <= byte_data[0];
            r_shift      <= {1'b0, byte_data[7:1]};
            r_bit        <= 3'd0;
            r_loaded     <= 1'b1;
            r_bytes_left <= r_bytes_left - LEN_W'(1);
            r_parity     <= r_parity ^ byte_data[0];
            valid_n      <= 1'b0;
            frame_n      <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  dout    <= 1'b0;
                  frame_n <= 1'b1;
                  valid_n <= 1'b1;
                  busy    <= 1'b0;
                  if (req_valid) begin
                     r_bytes_left <= w_len;
                     r_parity     <= 1'b0;
                     r_loaded     <= 1'b0;
                     r_cnt        <= '0;
                     if (w_len == '0) begin
                        r_state <= S_GAP;
                        done    <= 1'b1;
                     end else begin
                        r_state <= S_ADDR;
                        dout    <= req_addr[0];
                        r_addr  <= req_addr >> 1;
                        frame_n <= 1'b0;
                        busy    <= 1'b1;
                     end
                  end
               end
               S_ADDR: begin
                  if (r_cnt == c_ADDR_LAST) begin
                     r_state <= S_PAD;
                     dout    <= 1'b1;
                     r_cnt   <= '0;
                  end else begin
                     dout   <= r_addr[0];
                     r_addr <= r_addr >> 1;
                     r_cnt  <= r_cnt + CNT_W'(1);
                  end
               end
               S_PAD: begin
                  if (r_cnt == c_PAD_LAST) begin
                     r_state <= S_DATA;
                     dout    <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               S_DATA: begin
                  if (r_loaded && r_bit != 3'd7) begin
                     dout     <= r_shift[0];
                     r_shift  <= r_shift >> 1;
                     r_bit    <= r_bit + 3'd1;
                     r_parity <= r_parity ^ r_shift[0];
                     valid_n  <= 1'b0;
                     frame_n  <= (r_bit == 3'd6) && (r_bytes_left == '0) && !c_PARITY_EN;
                  end else if (r_loaded && r_bytes_left == '0) begin
                     if (c_PARITY_EN) begin
                        r_state <= S_PARITY;
                        dout    <= r_parity;
                        valid_n <= 1'b0;
                        frame_n <= 1'b1;
                     end else begin
                        r_state <= S_GAP;
                        dout    <= 1'b0;
                        valid_n <= 1'b1;
                        frame_n <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                     end
                  end else begin
                     // Starved at a byte boundary: bubble until the stream resumes.
                     dout     <= 1'b0;
                     valid_n  <= 1'b1;
                     frame_n  <= 1'b0;
                     r_loaded <= 1'b0;
                  end
               end
               S_PARITY: begin
                  r_state <= S_GAP;
                  dout    <= 1'b0;
                  valid_n <= 1'b1;
                  frame_n <= 1'b1;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
               S_GAP: begin
                  r_state <= S_IDLE;
                  dout    <= 1'b0;
                  frame_n <= 1'b1;
                  valid_n <= 1'b1;
                  busy    <= 1'b0;
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_tx.sv
`default_nettype none
// tb_router_pkt_tx : randomized self-checking bench for router_pkt_tx with a
// cycle-list reference model of each frame.
module tb_router_pkt_tx;

   localparam int ADDR_W     = 2;
   localparam int PAD_CYCLES = 3;
   localparam int MAX_BYTES  = 16;
   localparam int LEN_W      = $clog2(MAX_BYTES) + 1;
`ifdef ROUTER_TX_PARITY_EN
   localparam bit c_TB_PAR = 1'b1;
`else
   localparam bit c_TB_PAR = 1'b0;
`endif

   // {dout, frame_n, valid_n, busy, done, req_ready, byte_ready}
   typedef logic [6:0] obs_t;
   localparam obs_t c_IDLE  = 7'b0110010;
   localparam obs_t c_RESET = 7'b0110000;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              req_valid = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [LEN_W-1:0]  req_len = '0;
   logic              byte_valid = 1'b0;
   logic [7:0]        byte_data = '0;
   logic              req_ready, byte_ready, dout, frame_n, valid_n, busy, done;

   int   vectors = 0;
   int   miscompares = 0;
   obs_t exp_q[$];
   bit   start_q[$];
   logic [7:0] pkt[$];
   int   stall[$];

   always #5 clk = ~clk;

   router_pkt_tx #(
      .ADDR_W     (ADDR_W),
      .PAD_CYCLES (PAD_CYCLES),
      .MAX_BYTES  (MAX_BYTES)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_len    (req_len),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .byte_data  (byte_data),
      .dout       (dout),
      .frame_n    (frame_n),
      .valid_n    (valid_n),
      .busy       (busy),
      .done       (done)
   );

   function automatic obs_t mk(logic d, logic fn, logic vn, logic bz, logic dn);
      return {d, fn, vn, bz, dn, 2'b00};
   endfunction

   task automatic check(input string tag, input obs_t expv);
      obs_t obs;
      obs = {dout, frame_n, valid_n, busy, done, req_ready, byte_ready};
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, expv);
      end
   endtask

   task automatic push(input obs_t o, input bit st);
      exp_q.push_back(o);
      start_q.push_back(st);
   endtask

   // Expected wire activity, one entry per cycle after the accept cycle.
   task automatic build(input logic [ADDR_W-1:0] addr, input int n);
      bit         par;
      logic [7:0] v;
      obs_t       t;
      par = 1'b0;
      exp_q.delete();
      start_q.delete();
      if (n > 0) begin
         for (int i = 0; i < ADDR_W; i++) push(mk(addr[i], 0, 1, 1, 0), 0);
         for (int i = 0; i < PAD_CYCLES; i++) push(mk(1, 0, 1, 1, 0), 0);
         for (int b = 0; b < n; b++) begin
            for (int s = 0; s < stall[b]; s++) push(mk(0, 0, 1, 1, 0), 1);
            v = pkt[b];
            for (int i = 0; i < 8; i++) begin
               push(mk(v[i], (b == n - 1) && (i == 7) && !c_TB_PAR, 0, 1, 0), i == 0);
               par ^= v[i];
            end
         end
         if (c_TB_PAR) push(mk(par, 1, 0, 1, 0), 0);
      end
      push(mk(0, 1, 1, 0, 1), 0);
      push(c_IDLE, 0);
      // The stream is asked for a byte one cycle before a bubble or a bit 0.
      for (int k = 0; k + 1 < exp_q.size(); k++) begin
         if (start_q[k + 1]) begin
            t = exp_q[k];
            t[0] = 1'b1;
            exp_q[k] = t;
         end
      end
   endtask

   task automatic fill(input int n, input int maxstall);
      pkt.delete();
      stall.delete();
      for (int i = 0; i < n; i++) begin
         pkt.push_back(8'($urandom));
         stall.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, maxstall)) : 0);
      end
   endtask

   task automatic send(input string tag, input logic [ADDR_W-1:0] addr,
                       input int len, input int abort_at);
      int n;
      int bi;
      int refused;
      n = (len > MAX_BYTES) ? MAX_BYTES : len;
      bi = 0;
      refused = 0;
      build(addr, n);
      @(negedge clk);
      check($sformatf("%s/pre", tag), c_IDLE);
      req_valid  = 1'b1;
      req_addr   = addr;
      req_len    = LEN_W'(len);
      byte_valid = 1'($urandom_range(0, 1));
      byte_data  = 8'($urandom);
      for (int k = 0; k < exp_q.size(); k++) begin
         @(negedge clk);
         check($sformatf("%s/cyc%0d", tag, k + 1), exp_q[k]);
         req_valid = 1'b0;
         req_addr  = ADDR_W'($urandom);
         req_len   = LEN_W'($urandom);
         if (byte_ready && bi < n) begin
            if (refused < stall[bi]) begin
               byte_valid = 1'b0;
               refused++;
            end else begin
               byte_valid = 1'b1;
               byte_data  = pkt[bi];
               bi++;
               refused = 0;
            end
         end else begin
            byte_valid = 1'($urandom_range(0, 1));
            byte_data  = 8'($urandom);
         end
         if (k == abort_at) begin
            reset_n = 1'b0;
            break;
         end
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("por/held", c_RESET);
      reset_n = 1'b1;
      @(negedge clk);
      check("por/release", c_IDLE);

      pkt = '{8'hA5};
      stall = '{0};
      send("single_a5", 2'b10, 1, -1);

      pkt = '{8'h01, 8'h80};
      stall = '{0, 0};
      send("stream2", 2'b01, 2, -1);

      fill(2, 0);
      stall = '{0, 3};
      send("bubble3", 2'b11, 2, -1);

      fill(1, 0);
      stall = '{2};
      send("pad_starve", 2'b00, 1, -1);

      // Reset lands while bit 4 of the first byte is on the wire.
      fill(2, 0);
      send("abort", 2'b10, 2, 9);
      @(negedge clk);
      check("abort/reset", c_RESET);
      byte_valid = 1'b1;
      @(negedge clk);
      check("abort/held", c_RESET);
      reset_n = 1'b1;
      byte_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("abort/idle%0d", i), c_IDLE);
      end
      fill(1, 0);
      send("after_abort", 2'b01, 1, -1);

      fill(0, 0);
      send("len0", 2'b11, 0, -1);

      fill(MAX_BYTES, 2);
      send("len20", 2'b10, 20, -1);

      pkt = '{8'h07};
      stall = '{0};
      send("byte07", 2'b00, 1, -1);

      for (int p = 0; p < 8; p++) begin
         int len;
         len = $urandom_range(0, 20);
         fill(MAX_BYTES, 3);
         send($sformatf("rand%0d", p), ADDR_W'($urandom), len, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/router_pkt_tx.md
ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 SHALL have parameter ADDR_W, default 2, width of destination address serialized at frame start.
REQ-002 SHALL have parameter PAD_CYCLES, default 3, number of pad cycles between address and payload (legal range 1..15).
REQ-003 SHALL have parameter MAX_BYTES, default 16, maximum payload length in bytes.
REQ-004 SHALL use reset reset_n, synchronous, active-low; clock clk.
REQ-005 SHALL have ports: clk input 1 system clock; reset_n input 1 sync active-low reset.
REQ-006 SHALL have ports: req_valid input 1 packet request; req_ready output 1 request accept; req_addr input ADDR_W destination; req_len input clog2(MAX_BYTES)+1 payload byte count.
REQ-007 SHALL have ports: byte_valid input 1, byte_ready output 1, byte_data input 8 payload byte stream.
REQ-008 SHALL have ports: dout output 1 serial data; frame_n output 1 active-low frame; valid_n output 1 active-low data-valid; busy output 1 packet in progress; done output 1 end-of-packet pulse.

Function
REQ-009 SHALL implement FSM IDLE -> ADDR -> PAD -> DATA -> GAP -> IDLE; dout/frame_n/valid_n/busy/done all registered.
REQ-010 SHALL assert req_ready only in IDLE; request accepted on req_valid&req_ready, latching req_addr and req_len.
REQ-011 SHALL, in the cycle after acceptance, enter ADDR: frame_n=0, valid_n=1, dout=req_addr LSB first, ADDR_W cycles.
REQ-012 SHALL in PAD drive frame_n=0, valid_n=1, dout=1 for exactly PAD_CYCLES cycles.
REQ-013 SHALL in DATA drive frame_n=0, valid_n=0, dout=payload bits LSB first, bytes in arrival order.
REQ-014 SHALL assert byte_ready in the last PAD cycle, in the bit-7 cycle of each non-final byte, and in DATA whenever no byte is loaded; a byte loaded on byte_valid&byte_ready appears as bit 0 on the next cycle (no bubble when streaming).
REQ-015 SHALL, when no byte is available at a byte boundary, insert bubble cycles frame_n=0, valid_n=1, dout=0 until byte_valid.
REQ-016 SHALL drive frame_n=1 in the same cycle as the final payload bit (valid_n=0 on that cycle).
REQ-017 SHALL in GAP drive frame_n=1, valid_n=1, dout=0, pulse done=1 for one cycle, then return to IDLE (min one idle cycle between frames).
REQ-018 SHALL treat req_len=0 as accepted with no frame driven: done pulses the cycle after acceptance, busy stays 0.
REQ-019 SHALL clamp req_len>MAX_BYTES to MAX_BYTES.
REQ-020 SHALL hold busy=1 from ADDR through the final payload bit; ignore byte_valid outside PAD/DATA.

Reset
REQ-021 SHALL on reset_n=0 at a clk edge force IDLE, dout=0, frame_n=1, valid_n=1, busy=0, done=0, byte_ready=0, req_ready=0 during reset, req_ready=1 first cycle after release.
REQ-022 SHALL abort any frame on mid-packet reset: frame_n=1 next cycle, no done pulse, loaded byte discarded.

Configuration
REQ-023 SHALL, with macro ROUTER_TX_PARITY_EN defined, append one bit after the final payload bit, valid_n=0, dout=even parity over all payload bits, frame_n=1 on that parity bit instead of the last payload bit.
REQ-024 SHALL, without ROUTER_TX_PARITY_EN, produce no parity bit, behaviour per REQ-016.

Verification (ADDR_W=2, PAD_CYCLES=3, no parity unless stated)
REQ-025 SHALL cover: accept cycle 0, addr=2'b10, len=1, 0xA5 ready -> cycles 1-2 dout 0,1; 3-5 dout=1 valid_n=1; 6-13 dout 1,0,1,0,0,1,0,1 valid_n=0; frame_n=1 at 13; done at 14; req_ready at 15.
REQ-026 SHALL cover: len=2, 0x01 then 0x80 streamed back-to-back -> 16 contiguous valid_n=0 cycles, no bubble, frame_n rises on 16th.
REQ-027 SHALL cover: len=2, byte_valid low 3 cycles after first byte -> 3 bubble cycles valid_n=1 frame_n=0 dout=0, then second byte intact.
REQ-028 SHALL cover: reset_n=0 during DATA bit 4 -> next cycle frame_n=1 valid_n=1 busy=0, no done; new packet then transmits correctly.
REQ-029 SHALL cover: req_len=0 -> no frame_n low, done pulse cycle after accept; req_len=20 -> exactly 16 bytes sent.
REQ-030 SHALL cover: ROUTER_TX_PARITY_EN, len=1 byte 0x07 -> parity bit 1 follows data with valid_n=0, frame_n=1 only on parity bit.
